// File: rtl/qsd_serial_addsub_if.sv
// qsd_serial_addsub_if: operand/result handshake bundle for the digit-serial QSD adder/subtractor.
interface qsd_serial_addsub_if #(parameter int WIDTH = 64);
    localparam int NDIG = WIDTH / 2;
    logic                    in_valid;
    logic                    in_ready;
    logic                    op_sub;
    logic [WIDTH-1:0]        a;
    logic [WIDTH-1:0]        b;
    logic                    out_valid;
    logic                    out_ready;
    logic [3*(NDIG+1)-1:0]   res_qsd;
    logic [WIDTH:0]          res_bin;
    logic                    busy;
    modport master (output in_valid, op_sub, a, b, out_ready,
                    input  in_ready, out_valid, res_qsd, res_bin, busy);
    modport slave  (input  in_valid, op_sub, a, b, out_ready,
                    output in_ready, out_valid, res_qsd, res_bin, busy);
endinterface

// File: rtl/qsd_serial_addsub.sv
// qsd_serial_addsub: digit-serial carry-free radix-4 signed-digit adder/subtractor, DPC digits per beat.
module qsd_serial_addsub #(
    parameter int WIDTH = 64,
    parameter int DPC   = 4
) (
    input logic                clk,
    input logic                rst,
    qsd_serial_addsub_if.slave bus
);
    localparam int NDIG  = WIDTH / 2;
    localparam int BEATS = NDIG / DPC;
    localparam int BW    = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam int AW    = WIDTH + 1;
    localparam int QW    = 3 * (NDIG + 1);
    localparam int DW    = 2 * DPC;
    localparam logic [QW-1:0] DMASK = {{(QW-3*DPC){1'b0}}, {(3*DPC){1'b1}}};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nxt;

    logic [WIDTH-1:0] a_r, b_r;
    logic             sub_r;
    logic [BW-1:0]    beat;
    logic [1:0]       carry, c_out, c;
    logic [AW-1:0]    acc, acc_nxt, beat_sum, cterm;
    logic [QW-1:0]    qsd_r, qsd_nxt;
    logic [3*DPC-1:0] digs;
    logic [DW-1:0]    a_sh, b_sh;
    logic [2:0]       av, bv, s, d;
    logic signed [3:0] z;
    logic             last;
    int               base, qsh;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_nxt;

    always_comb begin
        state_nxt = state == IDLE ? (bus.in_valid ? RUN : IDLE)
                  : state == RUN  ? (last ? DONE : RUN)
                  : (bus.out_ready ? IDLE : DONE);
    end

    // Digits of the current beat; each digit sees only its right neighbour's transfer carry.
    always_comb begin
        base = 2 * DPC * int'(beat);
        qsh  = 3 * DPC * int'(beat);
        last = beat == BW'(BEATS - 1);
        a_sh = DW'(a_r >> base);
        b_sh = DW'(b_r >> base);
        c_out = carry;
        beat_sum = '0;
        digs = '0;
        av = '0;
        bv = '0;
        z = '0;
        c = '0;
        s = '0;
        d = '0;
        for (int j = 0; j < DPC; j++) begin
            av = {last && j == DPC - 1 && a_sh[2*j+1], a_sh[2*j +: 2]};
            bv = {last && j == DPC - 1 && b_sh[2*j+1], b_sh[2*j +: 2]};
            bv = sub_r ? -bv : bv;
            z = {av[2], av} + {bv[2], bv};
            c = z >= 4'sd3 ? 2'b01 : z <= -4'sd3 ? 2'b11 : 2'b00;
            s = z[2:0] - {c[0], 2'b00};
            d = s + {c_out[1], c_out};
            digs[3*j +: 3] = d;
            beat_sum = beat_sum + ({{(AW-3){d[2]}}, d} << (2 * j));
            c_out = c;
        end
        cterm = last ? ({{(AW-2){c_out[1]}}, c_out} << WIDTH) : '0;
        acc_nxt = acc + (beat_sum << base) + cterm;
        qsd_nxt = (qsd_r & ~(DMASK << qsh)) | ({{(QW-3*DPC){1'b0}}, digs} << qsh);
        if (last) qsd_nxt[QW-1 -: 3] = {c_out[1], c_out};
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            a_r   <= '0;
            b_r   <= '0;
            sub_r <= 1'b0;
            beat  <= '0;
            carry <= '0;
            acc   <= '0;
            qsd_r <= '0;
        end else if (state == IDLE && bus.in_valid) begin
            a_r   <= bus.a;
            b_r   <= bus.b;
            sub_r <= bus.op_sub;
            beat  <= '0;
            carry <= '0;
            acc   <= '0;
        end else if (state == RUN) begin
            beat  <= beat + 1'b1;
            carry <= c_out;
            acc   <= acc_nxt;
            qsd_r <= qsd_nxt;
        end

    assign bus.in_ready  = state == IDLE;
    assign bus.out_valid = state == DONE;
    assign bus.busy      = state != IDLE;
    assign bus.res_qsd   = qsd_r;
    assign bus.res_bin   = acc;
endmodule
